// File: rtl/present_g_layer_serial.sv
// Serial threshold-implementation PRESENT G layer: three shares in, one shared nibble per cycle out.
// Optional macro G_LAYER_REFRESH_EN adds an 8-bit rnd port that refreshes the output shares.
module present_g_layer_serial #(
  parameter int NIBBLES = 16,
  localparam int W  = 4 * NIBBLES,
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x1,
  input  logic [W-1:0]  x2,
  input  logic [W-1:0]  x3,
  input  logic          start,
`ifdef G_LAYER_REFRESH_EN
  input  logic [7:0]    rnd,
`endif
  output logic          busy,
  output logic [3:0]    y1,
  output logic [3:0]    y2,
  output logic [3:0]    y3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic [W-1:0]    sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  logic [3:0]      y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic            out_valid_q, out_valid_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic            hs, last, load;
  logic [3:0]      g1, g2, g3, r1, r2;

  // Output share built from two input shares (u, v): linear part u, product
  // part uu ^ uv ^ vu. Feeding (A2,A3), (A3,A1), (A1,A2) keeps it non-complete.
  function automatic logic [3:0] g_share(input logic [3:0] u, input logic [3:0] v);
    g_share[0] = u[0];
    g_share[1] = u[1];
    g_share[2] = u[2] ^ (u[0] & u[1]) ^ (u[0] & v[1]) ^ (v[0] & u[1]);
    g_share[3] = u[3] ^ (u[1] & u[2]) ^ (u[1] & v[2]) ^ (v[1] & u[2]);
  endfunction

  always_comb begin
    g1 = g_share(sh2_q[3:0], sh3_q[3:0]);
    g2 = g_share(sh3_q[3:0], sh1_q[3:0]);
    g3 = g_share(sh1_q[3:0], sh2_q[3:0]);
`ifdef G_LAYER_REFRESH_EN
    r1 = rnd[3:0];
    r2 = rnd[7:4];
`else
    r1 = 4'h0;
    r2 = 4'h0;
`endif
  end

  always_comb begin
    hs   = out_valid_q && out_ready;
    last = (out_idx_q == IW'(NIBBLES - 1));
    done = hs && last;
    load = (state_q == RUN) && armed_q && (!out_valid_q || (out_ready && !last));

    state_d     = state_q;
    armed_d     = armed_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    sh3_d       = sh3_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    y3_d        = y3_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;

    if (state_q == IDLE) begin
      if (start) begin
        state_d     = RUN;
        armed_d     = 1'b0;
        sh1_d       = x1;
        sh2_d       = x2;
        sh3_d       = x3;
        out_valid_d = 1'b0;
        out_idx_d   = '0;
      end
    end else begin
      // One idle cycle after capture gives nibble 0 its two-cycle latency.
      armed_d = 1'b1;
      if (load) begin
        y1_d        = g1 ^ r1;
        y2_d        = g2 ^ r2;
        y3_d        = g3 ^ r1 ^ r2;
        sh1_d       = sh1_q >> 4;
        sh2_d       = sh2_q >> 4;
        sh3_d       = sh3_q >> 4;
        out_valid_d = 1'b1;
        out_idx_d   = out_valid_q ? out_idx_q + IW'(1) : '0;
      end else if (done) begin
        out_valid_d = 1'b0;
        armed_d     = 1'b0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      sh3_q       <= '0;
      y1_q        <= 4'h0;
      y2_q        <= 4'h0;
      y3_q        <= 4'h0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      sh3_q       <= sh3_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      y3_q        <= y3_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign y1        = y1_q;
  assign y2        = y2_q;
  assign y3        = y3_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;

endmodule
